// File: rtl/fft_sample_loader.sv
// ---------------------------------------------------------------------------
// fft_sample_loader
//
// Input stage of the FFT datapath. Packs a byte stream into complex samples.
// Each sample is a real byte followed by an imaginary byte. The loader stores
// one N_POINTS frame in bit-reversed order. It then holds the frame for the
// FFT core, which reads it through a combinational random-access port. The
// core hands the frame back with a frame_valid / frame_ack handshake.
//
// Parameters
//   N_POINTS : samples per frame (power of two, 4..16)
//   LOG2N    : log2(N_POINTS), the buffer address width
//   DW       : bits per real or imaginary component
//
// Ports
//   clk, rst_n   : clock; asynchronous active-low reset
//   ena          : global enable; when low, all state is frozen
//   in_data      : stream byte (real first, then imaginary)
//   in_valid     : in_data is valid this cycle
//   in_ready     : loader accepts a byte this cycle (FILL and enabled)
//   frame_valid  : a complete frame is stored and held (registered)
//   frame_ack    : FFT core is done with the frame; the loader refills
//   rd_addr      : buffer read address
//   rd_re, rd_im : real / imaginary part at rd_addr (combinational)
//   sample_cnt   : samples completed in the current frame
//                  (reads N_POINTS while full)
//   overflow     : sticky flag, set when a byte is offered while full
// ---------------------------------------------------------------------------
module fft_sample_loader #(
  parameter int N_POINTS = 8,
  parameter int LOG2N    = 3,
  parameter int DW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             frame_valid,
  input  logic             frame_ack,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [DW-1:0]    rd_re,
  output logic [DW-1:0]    rd_im,
  output logic [LOG2N:0]   sample_cnt,
  output logic             overflow
);

  typedef enum logic { FILL, FULL } state_t;
  typedef enum logic { REAL, IMAG } phase_t;

  localparam logic [LOG2N:0] LAST_IDX = (LOG2N + 1)'(N_POINTS - 1);
  localparam logic [LOG2N:0] CNT_ONE  = (LOG2N + 1)'(1);

  state_t            state;
  phase_t            phase;
  logic [DW-1:0]     hold_re;
  logic [DW-1:0]     buf_re [N_POINTS];
  logic [DW-1:0]     buf_im [N_POINTS];

  logic              xfer;
  logic              pair_done;
  logic [LOG2N-1:0]  wr_addr;

  // Reverse the LOG2N address bits. Sample k lands at bitrev(k), so the
  // FFT core can run its butterflies in natural order.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // The loader is ready only while it is collecting a frame. Gating with ena
  // keeps the upstream side from counting a byte as sent while the loader
  // is frozen.
  assign in_ready  = (state == FILL) & ena;
  assign xfer      = in_valid & in_ready;
  assign pair_done = xfer & (phase == IMAG);
  assign wr_addr   = bitrev(sample_cnt[LOG2N-1:0]);

  // Control FSM: state, byte phase, sample counter, and registered flags.
  // NOTE: every sequential block uses non-blocking assignments, so all
  // registers update together from the values sampled at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      phase       <= REAL;
      hold_re     <= '0;
      sample_cnt  <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (ena) begin
      case (state)
        FILL: begin
          // In FILL, frame_ack is ignored on purpose. Only a held frame
          // can be released.
          if (xfer) begin
            if (phase == REAL) begin
              hold_re <= in_data;
              phase   <= IMAG;
            end else begin
              phase      <= REAL;
              sample_cnt <= sample_cnt + CNT_ONE;
              if (sample_cnt == LAST_IDX) begin
                state       <= FULL;
                frame_valid <= 1'b1;
              end
            end
          end
        end
        FULL: begin
          // A byte offered while full is dropped. This includes the cycle
          // in which the ack is taken.
          if (in_valid) begin
            overflow <= 1'b1;
          end
          if (frame_ack) begin
            state       <= FILL;
            phase       <= REAL;
            sample_cnt  <= '0;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  // Sample buffer. The real part comes from the holding register and the
  // imaginary part comes straight from the stream. Both are written in the
  // cycle the pair completes.
  // NOTE: the buffer has a reset. The whole frame must read zero after
  // reset, so this storage maps to flops and not to a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else if (ena && pair_done) begin
      buf_re[wr_addr] <= hold_re;
      buf_im[wr_addr] <= in_data;
    end
  end

  // Combinational read port. The contents cannot change while FULL, because
  // no transfer is accepted in that state.
  assign rd_re = buf_re[rd_addr];
  assign rd_im = buf_im[rd_addr];

endmodule

// File: tb/tb_fft_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_sample_loader
//
// Testbench for fft_sample_loader with N_POINTS = 8. A reference model keeps
// the bytes accepted in the current frame in a queue and derives the expected
// outputs from it. A compare process checks every output at each falling
// edge. Directed sections pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_fft_sample_loader;

  localparam int N  = 8;
  localparam int LN = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          frame_valid;
  logic          frame_ack;
  logic [LN-1:0] rd_addr;
  logic [DW-1:0] rd_re;
  logic [DW-1:0] rd_im;
  logic [LN:0]   sample_cnt;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  fft_sample_loader #(.N_POINTS(N), .LOG2N(LN), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_re       (rd_re),
    .rd_im       (rd_im),
    .sample_cnt  (sample_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned byte_q[$];     // bytes accepted in the current frame
  logic [7:0]   m_re [N];
  logic [7:0]   m_im [N];
  bit           m_full;
  bit           m_ovf;

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < LN; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_re[i] = '0;
        m_im[i] = '0;
      end
    end else if (ena) begin
      if (m_full) begin
        if (in_valid) m_ovf = 1'b1;
        if (frame_ack) begin
          m_full = 1'b0;
          byte_q.delete();
        end
      end else if (in_valid) begin
        byte_q.push_back(in_data);
        if (byte_q.size() % 2 == 0) begin
          int k;
          int a;
          k = byte_q.size() / 2 - 1;
          a = rev(k);
          m_re[a] = byte_q[2 * k];
          m_im[a] = byte_q[2 * k + 1];
          if (k == N - 1) m_full = 1'b1;
        end
      end
    end
  end

  // Compare process: check every output against the model at each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",    int'(in_ready),    int'(!m_full && ena));
      check("frame_valid", int'(frame_valid), int'(m_full));
      check("sample_cnt",  int'(sample_cnt),  byte_q.size() / 2);
      check("overflow",    int'(overflow),    int'(m_ovf));
      check("rd_re",       int'(rd_re),       int'(m_re[rd_addr]));
      check("rd_im",       int'(rd_im),       int'(m_im[rd_addr]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic ack);
    in_valid  = v;
    in_data   = d;
    ena       = e;
    frame_ack = ack;
    rd_addr   = LN'($urandom_range(0, N - 1));
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input int addr, input int re, input int im);
    rd_addr = LN'(addr);
    #1;
    check($sformatf("rd_re[%0d]", addr), int'(rd_re), re);
    check($sformatf("rd_im[%0d]", addr), int'(rd_im), im);
  endtask

  task automatic release_frame();
    for (int i = 0; i < 4 && m_full; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_data = '0; in_valid = 1'b0;
    frame_ack = 1'b0; rd_addr = '0;
    #1 cmp_en = 1'b1;
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset state
    check("rst in_ready", int'(in_ready), 1);
    check("rst frame_valid", int'(frame_valid), 0);
    check("rst sample_cnt", int'(sample_cnt), 0);
    check("rst overflow", int'(overflow), 0);
    for (int a = 0; a < N; a++) rd_chk(a, 0, 0);
    rst_n = 1'b1;

    // First frame: bytes 0x01..0x10 on consecutive cycles
    for (int i = 1; i <= 2 * N; i++) begin
      if (i == 2 * N) check("fv before last byte", int'(frame_valid), 0);
      drive(1'b1, 8'(i), 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    check("fv one cycle after last", int'(frame_valid), 1);
    check("cnt full", int'(sample_cnt), N);
    rd_chk(0, 8'h01, 8'h02);
    rd_chk(4, 8'h03, 8'h04);
    rd_chk(6, 8'h07, 8'h08);
    rd_chk(7, 8'h0F, 8'h10);

    // Overflow while FULL
    check("full in_ready", int'(in_ready), 0);
    repeat (3) drive(1'b1, 8'hAA, 1'b1, 1'b0);
    check("overflow set", int'(overflow), 1);
    rd_chk(7, 8'h0F, 8'h10);
    rd_chk(0, 8'h01, 8'h02);

    // The ack is taken and the byte offered in the same cycle is dropped
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    check("fv after ack", int'(frame_valid), 0);
    check("cnt after ack", int'(sample_cnt), 0);
    check("overflow sticky", int'(overflow), 1);

    // Second frame. frame_ack is pulsed while in FILL and must be ignored.
    for (int i = 0; i < 2 * N; i++) begin
      check("fv during fill", int'(frame_valid), 0);
      drive(1'b1, 8'(8'h20 + i), 1'b1, 1'(i % 2));
    end
    in_valid = 1'b0; frame_ack = 1'b0;
    check("fv frame2", int'(frame_valid), 1);
    rd_chk(4, 8'h22, 8'h23);
    rd_chk(0, 8'h20, 8'h21);

    // Random gaps, enable drops and acks
    for (int c = 0; c < 600; c++) begin
      logic v;
      logic e;
      logic k;
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      k = m_full ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      drive(v, 8'($urandom), e, k);
    end

    // Reset mid-frame after 5 bytes
    release_frame();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst in_ready", int'(in_ready), 1);
    check("midrst frame_valid", int'(frame_valid), 0);
    check("midrst sample_cnt", int'(sample_cnt), 0);
    check("midrst overflow", int'(overflow), 0);
    for (int a = 0; a < N; a++) rd_chk(a, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fresh frame with a gap between a real byte and its imaginary byte
    drive(1'b1, 8'h40, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 8'h99, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 8'h98, 1'b1, 1'b0);
    check("gap cnt held", int'(sample_cnt), 0);
    drive(1'b1, 8'h41, 1'b1, 1'b0);
    check("gap cnt advanced", int'(sample_cnt), 1);
    for (int i = 2; i < 2 * N; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    in_valid = 1'b0;
    check("fresh fv", int'(frame_valid), 1);
    rd_chk(0, 8'h40, 8'h41);
    rd_chk(4, 8'h42, 8'h43);
    rd_chk(7, 8'h4E, 8'h4F);

    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
